lc3_mem_if: RTL

// Memory/MMIO interface between the LC-3 control FSM/datapath and the external RAM port.

---
 rtl/lc3_mem_if_if.sv | 31 +++
 rtl/lc3_mem_if.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lc3_mem_if_if.sv
// RAM-side bus of the LC-3 memory interface.
//   master : the memory interface block (drives request, address, write data)
//   slave  : the RAM model / memory controller (returns read data and ack)
// Signals:
//   mem_req   request, held until mem_ack
//   mem_we    write enable, valid with mem_req
//   mem_addr  word address
//   mem_wdata write data
//   mem_rdata read data, valid with mem_ack
//   mem_ack   one-cycle completion strobe
interface lc3_mem_if_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lc3_mem_if.sv
// LC-3 memory / MMIO interface.
// Holds MAR/MDR, runs RAM accesses over the req/ack bus with an optional timeout,
// and serves the device registers KBSR/KBDR/DSR/DDR/MCR. Each access ends with
// a one-cycle ready pulse.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   bus_in            processor bus (MAR/MDR load source)
//   ld_mar, ld_mdr    register loads (honoured only while idle)
//   mio_en, r_w       start an access; r_w=1 write, 0 read
//   psr_15            user mode, used for access-violation check
//   mar, mdr          register contents
//   ready, acv        access complete pulse; registered access violation
//   mem               RAM bus (master side)
//   kb_valid, kb_data keyboard strobe and character
//   dsp_valid, dsp_data, dsp_busy  display strobe, character, busy
//   mcr_run           MCR[15], core clock enable
module lc3_mem_if #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TMO_CYC = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  bus_in,
  input  logic           ld_mar,
  input  logic           ld_mdr,
  input  logic           mio_en,
  input  logic           r_w,
  input  logic           psr_15,
  output logic [AW-1:0]  mar,
  output logic [DW-1:0]  mdr,
  output logic           ready,
  output logic           acv,
  lc3_mem_if_if.master   mem,
  input  logic           kb_valid,
  input  logic [7:0]     kb_data,
  output logic           dsp_valid,
  output logic [7:0]     dsp_data,
  input  logic           dsp_busy,
  output logic           mcr_run
);
  localparam int TW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);

  localparam logic [AW-1:0] A_MMIO = AW'(16'hFE00);
  localparam logic [AW-1:0] A_KBSR = AW'(16'hFE00);
  localparam logic [AW-1:0] A_KBDR = AW'(16'hFE02);
  localparam logic [AW-1:0] A_DSR  = AW'(16'hFE04);
  localparam logic [AW-1:0] A_DDR  = AW'(16'hFE06);
  localparam logic [AW-1:0] A_MCR  = AW'(16'hFFFE);

  typedef enum logic [1:0] {IDLE, RAM, DEV, DONE} state_t;
  state_t state, state_d;

  logic          acc_we;    // r_w captured when the access starts
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          kb_rdy;
  logic [7:0]    kbdr;
  logic [DW-1:0] dev_rdata;

  // Bus outputs decode straight from the state flop so reset drops mem_req at once.
  assign mem.mem_req   = (state == RAM);
  assign mem.mem_we    = (state == RAM) & acc_we;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;
  assign ready         = (state == DONE);

  // Ack has priority over a timeout landing in the same cycle.
  assign tmo_hit = (TMO_CYC != 0) && (state == RAM) && (tmo_cnt == TMO_LAST) && !mem.mem_ack;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (mio_en) state_d = acv ? DONE : (mar >= A_MMIO) ? DEV : RAM;
      RAM:  if (mem.mem_ack || tmo_hit) state_d = DONE;
      DEV:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dev_rdata = '0;
    case (mar)
      A_KBSR: dev_rdata[DW-1] = kb_rdy;
      A_KBDR: dev_rdata[7:0]  = kbdr;
      A_DSR:  dev_rdata[DW-1] = ~dsp_busy;
      A_MCR:  dev_rdata[DW-1] = mcr_run;
      default: dev_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      acv       <= 1'b0;
      acc_we    <= 1'b0;
      tmo_cnt   <= '0;
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
      mcr_run   <= 1'b1;
    end else begin
      state     <= state_d;
      dsp_valid <= 1'b0;
      tmo_cnt   <= (state == RAM) ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE) begin
        if (ld_mar) begin
          mar <= AW'(bus_in);
          acv <= psr_15 & ((bus_in < DW'(16'h3000)) | (bus_in >= DW'(16'hFE00)));
        end
        if (ld_mdr && !mio_en) mdr <= bus_in;
        if (mio_en) acc_we <= r_w;
      end
      if (state == RAM && !acc_we) begin
        if (mem.mem_ack)  mdr <= mem.mem_rdata;
        else if (tmo_hit) mdr <= '0;
      end
      if (state == DEV) begin
        if (!acc_we) mdr <= dev_rdata;
        else if (mar == A_DDR) begin
          dsp_valid <= 1'b1;
          dsp_data  <= mdr[7:0];
        end else if (mar == A_MCR) mcr_run <= mdr[DW-1];
      end
    end
  end

  // A new character beats a KBDR read clearing the flag in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_rdy <= 1'b0;
      kbdr   <= '0;
    end else if (kb_valid) begin
      kb_rdy <= 1'b1;
      kbdr   <= kb_data;
    end else if (state == DEV && !acc_we && mar == A_KBDR) begin
      kb_rdy <= 1'b0;
    end
  end
endmodule
